// File: rtl/load_unit.sv
// Data-memory load stage: req/ack/rvalid bus read with byte/half/word extraction and a cycle timeout.
// Optional MISALIGN_TRAP_EN: misaligned LH/LHU/LW complete immediately with ld_misalign instead of reading.
module load_unit #(
  parameter int unsigned TIMEOUT_CYC = 256
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ld_start,
  input  logic [31:0] ld_addr,
  input  logic [2:0]  ld_funct3,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [31:0] readdata,
  output logic        ld_done,
  output logic        ld_err,
  output logic        ld_misalign,
  output logic        busy
);

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DONE} state_t;

  // Counter only needs to reach TIMEOUT_CYC-1; it saturates beyond that.
  localparam int unsigned CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         lo_q, lo_d;
  logic [2:0]         f3_q, f3_d;
  logic [31:0]        mem_addr_q, mem_addr_d;
  logic [31:0]        readdata_q, readdata_d;
  logic               mem_req_q, mem_req_d;
  logic               ld_done_q, ld_done_d;
  logic               ld_err_q, ld_err_d;
  logic               ld_mis_q, ld_mis_d;
  logic               busy_q, busy_d;
  logic               tmo_hit;
  logic               trap;

  function automatic logic [31:0] extract(input logic [31:0] w, input logic [1:0] a,
                                          input logic [2:0] f3);
    logic [7:0]  b;
    logic [15:0] h;
    b = w[{a, 3'b000} +: 8];
    h = w[{a[1], 4'b0000} +: 16];
    case (f3)
      3'b000:  extract = {{24{b[7]}}, b};
      3'b001:  extract = {{16{h[15]}}, h};
      3'b100:  extract = {24'h000000, b};
      3'b101:  extract = {16'h0000, h};
      default: extract = w;
    endcase
  endfunction

`ifdef MISALIGN_TRAP_EN
  always_comb begin
    trap = 1'b0;
    case (ld_funct3)
      3'b000, 3'b100: trap = 1'b0;
      3'b001, 3'b101: trap = ld_addr[0];
      default:        trap = (ld_addr[1:0] != 2'b00);
    endcase
  end
`else
  assign trap = 1'b0;
`endif

  assign tmo_hit = (TIMEOUT_CYC != 0) && (32'(cnt_q) == TIMEOUT_CYC - 1);

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    lo_d       = lo_q;
    f3_d       = f3_q;
    mem_addr_d = mem_addr_q;
    readdata_d = readdata_q;
    ld_err_d   = 1'b0;
    ld_mis_d   = 1'b0;

    if ((state_q == S_REQ) || (state_q == S_WAIT)) begin
      if (cnt_q != '1) cnt_d = cnt_q + CNT_W'(1);
    end

    case (state_q)
      S_IDLE: begin
        if (ld_start) begin
          lo_d = ld_addr[1:0];
          f3_d = ld_funct3;
          if (trap) begin
            state_d    = S_DONE;
            readdata_d = '0;
            ld_mis_d   = 1'b1;
          end else begin
            state_d    = S_REQ;
            mem_addr_d = {ld_addr[31:2], 2'b00};
            cnt_d      = '0;
          end
        end
      end
      S_REQ: begin
        // Data beats timeout in the same cycle; ack alone still yields to timeout.
        if (mem_ack && mem_rvalid) begin
          state_d    = S_DONE;
          readdata_d = extract(mem_rdata, lo_q, f3_q);
        end else if (tmo_hit) begin
          state_d    = S_DONE;
          readdata_d = '0;
          ld_err_d   = 1'b1;
        end else if (mem_ack) begin
          state_d = S_WAIT;
        end
      end
      S_WAIT: begin
        if (mem_rvalid) begin
          state_d    = S_DONE;
          readdata_d = extract(mem_rdata, lo_q, f3_q);
        end else if (tmo_hit) begin
          state_d    = S_DONE;
          readdata_d = '0;
          ld_err_d   = 1'b1;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    mem_req_d = (state_d == S_REQ);
    ld_done_d = (state_d == S_DONE);
    busy_d    = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      lo_q       <= '0;
      f3_q       <= '0;
      mem_addr_q <= '0;
      readdata_q <= '0;
      mem_req_q  <= 1'b0;
      ld_done_q  <= 1'b0;
      ld_err_q   <= 1'b0;
      ld_mis_q   <= 1'b0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      lo_q       <= lo_d;
      f3_q       <= f3_d;
      mem_addr_q <= mem_addr_d;
      readdata_q <= readdata_d;
      mem_req_q  <= mem_req_d;
      ld_done_q  <= ld_done_d;
      ld_err_q   <= ld_err_d;
      ld_mis_q   <= ld_mis_d;
      busy_q     <= busy_d;
    end
  end

  assign mem_req     = mem_req_q;
  assign mem_addr    = mem_addr_q;
  assign readdata    = readdata_q;
  assign ld_done     = ld_done_q;
  assign ld_err      = ld_err_q;
  assign ld_misalign = ld_mis_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_load_unit.sv
// Randomized self-checking bench for load_unit against a cycle-count/arithmetic reference model.
module tb_load_unit;
  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic        ld_start;
  logic [31:0] ld_addr;
  logic [2:0]  ld_funct3;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] readdata;
  logic        ld_done;
  logic        ld_err;
  logic        ld_misalign;
  logic        busy;

  int checks = 0;
  int errors = 0;
  logic [31:0] last_rd = '0;

  load_unit #(.TIMEOUT_CYC(TMO)) dut (
    .clk(clk), .rst(rst), .ld_start(ld_start), .ld_addr(ld_addr), .ld_funct3(ld_funct3),
    .mem_req(mem_req), .mem_addr(mem_addr), .mem_ack(mem_ack), .mem_rvalid(mem_rvalid),
    .mem_rdata(mem_rdata), .readdata(readdata), .ld_done(ld_done), .ld_err(ld_err),
    .ld_misalign(ld_misalign), .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_rd(input logic [31:0] addr, input logic [2:0] f3,
                                           input logic [31:0] w);
    logic [31:0] b, h;
    b = (w >> (8 * (addr % 4))) & 32'hFF;
    h = (w >> (16 * ((addr / 2) % 2))) & 32'hFFFF;
    case (f3)
      3'd0:    return (b >= 128) ? b + 32'hFFFF_FF00 : b;
      3'd1:    return (h >= 32768) ? h + 32'hFFFF_0000 : h;
      3'd4:    return b;
      3'd5:    return h;
      default: return w;
    endcase
  endfunction

  function automatic bit model_mis(input logic [31:0] addr, input logic [2:0] f3);
`ifdef MISALIGN_TRAP_EN
    if (f3 == 3'd0 || f3 == 3'd4) return 1'b0;
    if (f3 == 3'd1 || f3 == 3'd5) return (addr % 2) != 0;
    return (addr % 4) != 0;
`else
    return 1'b0;
`endif
  endfunction

  // a = REQ cycles without ack before the ack cycle; r = cycles from ack to rvalid.
  task automatic do_load(input logic [31:0] addr, input logic [2:0] f3, input logic [31:0] w,
                         input int a, input int r);
    int done_c, req_end;
    bit mis, tmo;
    logic [31:0] exp_rd;
    mis = model_mis(addr, f3);
    tmo = 1'b0;
    if (mis) begin
      done_c = 1; req_end = 0; exp_rd = '0;
    end else if (1 + a + r <= int'(TMO)) begin
      done_c = 2 + a + r; req_end = 1 + a; exp_rd = model_rd(addr, f3, w);
    end else begin
      done_c = TMO + 1; tmo = 1'b1; exp_rd = '0;
      req_end = (1 + a < int'(TMO)) ? 1 + a : int'(TMO);
    end
    ld_start = 1'b1; ld_addr = addr; ld_funct3 = f3;
    for (int c = 1; c <= done_c + 1; c++) begin
      @(posedge clk); #1;
      check("mem_req", {31'd0, mem_req}, {31'd0, c <= req_end});
      check("busy", {31'd0, busy}, {31'd0, c <= done_c});
      check("ld_done", {31'd0, ld_done}, {31'd0, c == done_c});
      if (c <= req_end) check("mem_addr", mem_addr, addr & 32'hFFFF_FFFC);
      if (c == done_c) begin
        check("readdata", readdata, exp_rd);
        check("ld_err", {31'd0, ld_err}, {31'd0, tmo});
        check("ld_misalign", {31'd0, ld_misalign}, {31'd0, mis});
      end else begin
        check("readdata_hold", readdata, (c < done_c) ? last_rd : exp_rd);
      end
      ld_start   = (c == done_c) ? 1'($urandom % 2) : 1'b0;
      mem_ack    = !mis && (c == 1 + a);
      mem_rvalid = !mis && ((c == 1 + a + r) || (c < 1 + a && ($urandom % 4) == 0) ||
                            (c >= done_c));
      mem_rdata  = (!mis && c == 1 + a + r) ? w : $urandom;
    end
    ld_start = 1'b0; mem_ack = 1'b0; mem_rvalid = 1'b0;
    last_rd = exp_rd;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_readdata"}, readdata, '0);
    check({tag, "_mem_addr"}, mem_addr, '0);
    check({tag, "_flags"}, {27'd0, mem_req, ld_done, ld_err, ld_misalign, busy}, '0);
  endtask

  initial begin
    rst = 1'b1; ld_start = 1'b0; ld_addr = '0; ld_funct3 = '0;
    mem_ack = 1'b0; mem_rvalid = 1'b0; mem_rdata = '0;
    #2;
    check_all_zero("reset");
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    do_load(32'h1003, 3'd0, 32'h80FF7F01, 0, 0);
    do_load(32'h1003, 3'd4, 32'h80FF7F01, 1, 0);
    do_load(32'h1001, 3'd0, 32'h80FF7F01, 0, 1);
    do_load(32'h1002, 3'd1, 32'h80FF7F01, 0, 0);
    do_load(32'h1002, 3'd5, 32'h80FF7F01, 2, 1);
    do_load(32'h1000, 3'd2, 32'h80FF7F01, 0, 0);
    do_load(32'h2004, 3'd2, 32'hCAFEF00D, 3, 2);
    do_load(32'h3000, 3'd2, 32'h12345678, 20, 0);
    do_load(32'h1001, 3'd2, 32'h80FF7F01, 0, 0);
    do_load(32'h4000, 3'd2, 32'hA5A5A5A5, 6, 1);
    do_load(32'h4000, 3'd2, 32'hA5A5A5A5, 6, 2);

    // Reset while waiting for rvalid; late rvalid must be ignored.
    ld_start = 1'b1; ld_addr = 32'h2000; ld_funct3 = 3'd2;
    @(posedge clk); #1;
    ld_start = 1'b0; mem_ack = 1'b1;
    @(posedge clk); #1;
    mem_ack = 1'b0;
    check("wait_busy", {31'd0, busy}, 32'd1);
    check("wait_req", {31'd0, mem_req}, 32'd0);
    rst = 1'b1;
    #1;
    check_all_zero("midreset");
    @(posedge clk); #1;
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mem_rvalid = 1'b1; mem_rdata = $urandom;
      @(posedge clk); #1;
      check("late_done", {31'd0, ld_done}, 32'd0);
      check("late_busy", {31'd0, busy}, 32'd0);
    end
    mem_rvalid = 1'b0;
    last_rd = '0;
    do_load(32'h2000, 3'd2, 32'h0BADBEEF, 0, 1);

    for (int n = 0; n < 150; n++) begin
      do_load($urandom, 3'($urandom % 8), $urandom, int'($urandom % 10), int'($urandom % 5));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1);
  end
endmodule
